bus_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter acting as responder on the core's data bus (ce/wre/ad/din/dout).

---
 rtl/bus_uart_tx.sv | 232 +++++++++++++++++++++++
 tb/tb_bus_uart_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped UART transmitter on the core data bus.
// Bytes written to TXDATA queue in a TX FIFO and go out on txd, LSB first.
// Default build sends 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
//
// state    | meaning
// ---------+-------------------------------------------
// S_IDLE   | line high, waiting for a byte and tx_enable
// S_START  | start bit (txd low)
// S_DATA   | 8 data bits, LSB first
// S_PARITY | even parity bit (UART_TX_PARITY_EN only)
// S_STOP   | stop bit (txd high)
module bus_uart_tx #(
    parameter logic [7:0]  BASE_ADDR   = 8'hF0,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd234
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        wre,
    input  logic [7:0]  ad,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        txd
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          state;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            overflow;
    logic [15:0]     baud_div;
    logic            tx_enable;
    logic [15:0]     bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic            parity_bit;

    logic            hit;
    logic            wr_en;
    logic            rd_en;
    logic            push_req;
    logic            push_ok;
    logic            pop;
    logic            fifo_empty;
    logic            fifo_full;
    logic            busy;
    logic            bit_end;
    logic [15:0]     div_load;
    logic [31:0]     rd_data;

    // Bus decode, FIFO status and bit-timing helpers
    always_comb begin
        hit        = (ad[7:2] == BASE_ADDR[7:2]);
        wr_en      = ce & wre & hit;
        rd_en      = ce & ~wre & hit;
        fifo_empty = (count == '0);
        fifo_full  = (count == CW'(FIFO_DEPTH));
        push_req   = wr_en & (ad[1:0] == 2'd0);
        // fullness is judged before this edge's pop, so a push while full is always dropped
        push_ok    = push_req & ~fifo_full;
        busy       = (state != S_IDLE);
        bit_end    = (bit_cnt == 16'd0);
        // bit period of 0 behaves as 1; the counter runs period-1 down to 0
        div_load   = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
        pop        = tx_enable & ~fifo_empty &
                     ((state == S_IDLE) | ((state == S_STOP) & bit_end));
    end

    // Read mux, reflecting state before the current edge
    always_comb begin
        rd_data = 32'h0;
        case (ad[1:0])
            2'd1: begin
                rd_data[15:8] = 8'(count);
                rd_data[3]    = overflow;
                rd_data[2]    = fifo_full;
                rd_data[1]    = fifo_empty;
                rd_data[0]    = busy;
            end
            2'd2:    rd_data[15:0] = baud_div;
            2'd3:    rd_data[0]    = tx_enable;
            default: rd_data = 32'h0;
        endcase
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= din[7:0];
        end
    end

    // Registers, FIFO pointers/count and registered read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout      <= 32'h0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            baud_div  <= DEFAULT_DIV;
            tx_enable <= 1'b1;
        end else begin
            dout <= rd_en ? rd_data : 32'h0;

            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (push_req & fifo_full) begin
                overflow <= 1'b1;
            end else if (wr_en & (ad[1:0] == 2'd1) & din[3]) begin
                overflow <= 1'b0;
            end

            if (wr_en & (ad[1:0] == 2'd2)) begin
                baud_div <= din[15:0];
            end
            if (wr_en & (ad[1:0] == 2'd3)) begin
                tx_enable <= din[0];
            end
        end
    end

    // TX frame sequencer; each bit lasts div_load+1 cycles, reloaded at every bit boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            txd        <= 1'b1;
            bit_cnt    <= 16'd0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'h0;
            parity_bit <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shift_reg  <= fifo_mem[rd_ptr];
                        parity_bit <= ^fifo_mem[rd_ptr];
                        bit_cnt    <= div_load;
                        txd        <= 1'b0;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        bit_cnt <= div_load;
                        bit_idx <= 3'd0;
                        txd     <= shift_reg[0];
                        state   <= S_DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= div_load;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            txd   <= parity_bit;
                            state <= S_PARITY;
`else
                            txd   <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            txd       <= shift_reg[1];
                            shift_reg <= {1'b0, shift_reg[7:1]};
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        bit_cnt <= div_load;
                        txd     <= 1'b1;
                        state   <= S_STOP;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        bit_cnt <= div_load;
                        // chain straight into the next frame when a byte is waiting
                        if (pop) begin
                            shift_reg  <= fifo_mem[rd_ptr];
                            parity_bit <= ^fifo_mem[rd_ptr];
                            txd        <= 1'b0;
                            state      <= S_START;
                        end else begin
                            txd   <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: register-access vector table plus frame-timing sequences.
module tb_bus_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    localparam logic [7:0] A_TX   = 8'hF0;
    localparam logic [7:0] A_ST   = 8'hF1;
    localparam logic [7:0] A_BAUD = 8'hF2;
    localparam logic [7:0] A_CTRL = 8'hF3;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        wre;
    logic [7:0]  ad;
    logic [31:0] din;
    logic [31:0] dout;
    logic        txd;

    int n_checks = 0;
    int n_fail   = 0;

    bus_uart_tx dut (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .wre  (wre),
        .ad   (ad),
        .din  (din),
        .dout (dout),
        .txd  (txd)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input string n, input logic w, input logic [7:0] a,
                                    input logic [31:0] d, input logic c, input logic [31:0] e);
        vec_t v;
        v.name = n; v.wr = w; v.addr = a; v.data = d; v.chk = c; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        ce = 1'b1; wre = 1'b1; ad = a; din = d;
        @(negedge clk);
        ce = 1'b0; wre = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        ce = 1'b1; wre = 1'b0; ad = a;
        @(negedge clk);
        ce = 1'b0;
        d = dout;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9 && NB == 11) return ^b;
        return 1'b1;
    endfunction

    // Checks one frame cycle by cycle at negedges. Bits with index < sw_idx use div_a,
    // the rest div_b. If op_cyc >= 0 a bus access is driven during that frame cycle.
    task automatic check_frame(input string name, input logic [7:0] b,
                               input int div_a, input int div_b, input int sw_idx,
                               input int op_cyc, input logic op_wre,
                               input logic [7:0] op_ad, input logic [31:0] op_din,
                               input bit wait_start);
        int   cyc;
        int   per;
        bit   found;
        bit   ok;
        logic e;
        logic bad_val;
        cyc = 0;
        if (wait_start) begin
            found = 1'b0;
            for (int t = 0; t < 2000 && !found; t++) begin
                @(negedge clk);
                if (txd === 1'b0) found = 1'b1;
            end
            n_checks++;
            if (!found) begin
                n_fail++;
                $display("FAIL %s_start: txd=%b, expected 0 within 2000 cycles", name, txd);
                return;
            end
        end else begin
            @(negedge clk);
        end
        for (int i = 0; i < NB; i++) begin
            per = (i < sw_idx) ? div_a : div_b;
            e = frame_bit(b, i);
            ok = 1'b1;
            bad_val = e;
            for (int c = 0; c < per; c++) begin
                if (cyc != 0) @(negedge clk);
                if (op_cyc >= 0) begin
                    ce = (cyc == op_cyc); wre = op_wre; ad = op_ad; din = op_din;
                end
                if (txd !== e) begin
                    ok = 1'b0;
                    bad_val = txd;
                end
                cyc++;
            end
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s_bit%0d: txd=%b in some cycle, expected %b for %0d cycles",
                         name, i, bad_val, e, per);
            end
        end
    endtask

    logic [31:0] rd;

    initial begin
        rst = 1'b1; ce = 1'b0; wre = 1'b0; ad = 8'h00; din = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_txd", {31'b0, txd}, 32'd1);
        check("rst_dout", dout, 32'h0);
        rst = 1'b0;

        // register map / decode vectors
        add_vec("rst_status",   0, A_ST,   32'h0,         1, 32'h0000_0002);
        add_vec("rst_baud",     0, A_BAUD, 32'h0,         1, 32'd234);
        add_vec("rst_ctrl",     0, A_CTRL, 32'h0,         1, 32'h1);
        add_vec("txdata_rd",    0, A_TX,   32'h0,         1, 32'h0);
        add_vec("baud_wr",      1, A_BAUD, 32'h1234_5678, 0, 32'h0);
        add_vec("baud_rd",      0, A_BAUD, 32'h0,         1, 32'h0000_5678);
        add_vec("baud_wr0",     1, A_BAUD, 32'h0,         0, 32'h0);
        add_vec("baud_rd0",     0, A_BAUD, 32'h0,         1, 32'h0);
        add_vec("ctrl_wr0",     1, A_CTRL, 32'hFFFF_FFFE, 0, 32'h0);
        add_vec("ctrl_rd0",     0, A_CTRL, 32'h0,         1, 32'h0);
        add_vec("ctrl_wr1",     1, A_CTRL, 32'h0000_0003, 0, 32'h0);
        add_vec("ctrl_rd1",     0, A_CTRL, 32'h0,         1, 32'h1);
        add_vec("nonhit_rd",    0, 8'h10,  32'h0,         1, 32'h0);
        add_vec("nonhit_wrb",   1, 8'h12,  32'h77,        0, 32'h0);
        add_vec("nonhit_baud",  0, A_BAUD, 32'h0,         1, 32'h0);
        add_vec("nonhit_wrc",   1, 8'hEF,  32'h0,         0, 32'h0);
        add_vec("nonhit_ctrl",  0, A_CTRL, 32'h0,         1, 32'h1);
        add_vec("nonhit_wrtx",  1, 8'h10,  32'hAB,        0, 32'h0);
        add_vec("nonhit_stat",  0, A_ST,   32'h0,         1, 32'h0000_0002);
        add_vec("w1c_empty",    1, A_ST,   32'h8,         0, 32'h0);
        add_vec("w1c_stat",     0, A_ST,   32'h0,         1, 32'h0000_0002);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, rd);
                if (vecs[i].chk) check(vecs[i].name, rd, vecs[i].exp);
            end
        end

        // T2: single frame 0x55 at 4 cycles per bit
        bus_write(A_BAUD, 32'd4);
        bus_write(A_TX, 32'h55);
        check_frame("t2", 8'h55, 4, 4, 99, -1, 1'b0, 8'h00, 32'h0, 1'b1);
        @(negedge clk);
        check("t2_idle_txd", {31'b0, txd}, 32'd1);
        bus_read(A_ST, rd);
        check("t2_status", rd, 32'h0000_0002);

        // T5: BAUDDIV 4 -> 8 written mid data bit 3
        bus_write(A_TX, 32'hC3);
        check_frame("t5", 8'hC3, 4, 8, 5, 17, 1'b1, A_BAUD, 32'd8, 1'b1);
        @(negedge clk);
        ce = 1'b0;
        bus_read(A_BAUD, rd);
        check("t5_baud", rd, 32'd8);

        // T3: overflow with transmitter disabled
        bus_write(A_CTRL, 32'h0);
        for (int i = 0; i < 9; i++) bus_write(A_TX, 32'h10 + i);
        bus_read(A_ST, rd);
        check("t3_status_ovf", rd, 32'h0000_080C);
        bus_write(A_ST, 32'h8);
        bus_read(A_ST, rd);
        check("t3_status_clr", rd, 32'h0000_0804);

        // T1: reset in the middle of a frame
        bus_write(A_BAUD, 32'd100);
        bus_write(A_CTRL, 32'h1);
        begin
            bit found;
            found = 1'b0;
            for (int t = 0; t < 200 && !found; t++) begin
                @(negedge clk);
                if (txd === 1'b0) found = 1'b1;
            end
            check("t1_start_seen", {31'b0, found}, 32'd1);
        end
        repeat (10) @(negedge clk);
        ce = 1'b1; wre = 1'b0; ad = A_BAUD;
        @(posedge clk);
        #1;
        check("t1_pre_dout", dout, 32'd100);
        check("t1_pre_txd", {31'b0, txd}, 32'd0);
        rst = 1'b1;
        #1;
        check("t1_rst_txd", {31'b0, txd}, 32'd1);
        check("t1_rst_dout", dout, 32'h0);
        @(negedge clk);
        ce = 1'b0;
        rst = 1'b0;
        bus_read(A_ST, rd);
        check("t1_status", rd, 32'h0000_0002);
        bus_read(A_BAUD, rd);
        check("t1_baud", rd, 32'd234);

        // T4: three queued bytes sent back to back at 2 cycles per bit
        bus_write(A_CTRL, 32'h0);
        bus_write(A_BAUD, 32'd2);
        bus_write(A_TX, 32'hA1);
        bus_write(A_TX, 32'h02);
        bus_write(A_TX, 32'hFF);
        bus_write(A_CTRL, 32'h1);
        check_frame("t4a", 8'hA1, 2, 2, 99, -1, 1'b0, 8'h00, 32'h0, 1'b1);
        check_frame("t4b", 8'h02, 2, 2, 99, -1, 1'b0, 8'h00, 32'h0, 1'b0);
        check_frame("t4c", 8'hFF, 2, 2, 99, NB * 2 - 1, 1'b0, A_ST, 32'h0, 1'b0);
        // read issued in the last stop cycle still sees busy; the next one sees idle
        @(negedge clk);
        check("t4_busy_last", dout, 32'h0000_0003);
        check("t4_txd_idle", {31'b0, txd}, 32'd1);
        @(negedge clk);
        ce = 1'b0;
        check("t4_busy_drop", dout, 32'h0000_0002);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
